multdiv_sequencer: RTL and testbench

Sequences the multi-cycle multiplier/divider unit on behalf of the execute stage. Decodes mult/div in the D/X instruction and issues a single-cycle start pulse. Holds the pipeline stalled until the unit reports ready, then presents the result, destination register and exception status for one cycle. Sits between the D/X latch outputs (after forwarding) and the multdiv unit, and drives the pipeline-wide stall.

---
 rtl/multdiv_sequencer_pkg.sv | 39 +++
 rtl/multdiv_busy_counter.sv | 29 ++
 rtl/multdiv_sequencer.sv | 137 +++++++++++++
 tb/tb_multdiv_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_sequencer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// multdiv_sequencer_pkg: decode constants, state encoding, helpers.
// Rev 1.0
// ------------------------------------------------------------------
package multdiv_sequencer_pkg;

  localparam logic [4:0] c_opcode_alu = 5'b00000;
  localparam logic [4:0] c_aluop_mult = 5'b00110;
  localparam logic [4:0] c_aluop_div  = 5'b00111;

  // $rstatus values execute uses when building setx for a faulting op
  localparam logic [31:0] c_rstatus_mult = 32'd4;
  localparam logic [31:0] c_rstatus_div  = 32'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } md_kind_e;

  function automatic md_kind_e decode_md(input logic [4:0] opcode, input logic [4:0] aluop);
    md_kind_e kind;
    kind = MD_NONE;
    if (opcode == c_opcode_alu) begin
      if (aluop == c_aluop_mult)     kind = MD_MULT;
      else if (aluop == c_aluop_div) kind = MD_DIV;
    end
    return kind;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multdiv_busy_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// multdiv_busy_counter: busy-cycle counter, flags the last allowed cycle.
// Rev 1.0
// ------------------------------------------------------------------
module multdiv_busy_counter #(
  parameter int CNT_W = 6,
  parameter int LIMIT = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_at_limit
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst)           r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_enable) r_count <= r_count + 1'b1;
  end

  // Count starts at 0 on the first busy cycle, so LIMIT-1 marks the LIMIT-th one
  assign o_at_limit = (r_count == CNT_W'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// multdiv_sequencer: launches mult/div from D/X, stalls until completion.
// Rev 1.0
// ------------------------------------------------------------------
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] d_x_instruction,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_result_rdy,
  output logic        ctrlMULT,
  output logic        ctrlDIV,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  output logic        stall,
  output logic [31:0] result,
  output logic [4:0]  result_rd,
  output logic        result_valid,
  output logic        mult_exception,
  output logic        div_exception,
  output logic        timeout_error
);

  state_t      r_state;
  state_t      w_state_nxt;
  md_kind_e    w_kind;
  logic        w_launch;
  logic        w_busy;
  logic        w_finish;
  logic        w_at_limit;
  logic        w_unused_instr_bits;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic [4:0]  r_rd;
  logic        r_op_mult;
  logic [31:0] r_result;
  logic [4:0]  r_result_rd;
  logic        r_exc;
  logic        r_timeout;

  assign w_kind              = decode_md(d_x_instruction[31:27], d_x_instruction[6:2]);
  assign w_unused_instr_bits = ^{d_x_instruction[21:7], d_x_instruction[1:0]};
  assign w_busy              = (r_state == S_BUSY);
  assign w_launch            = (r_state == S_IDLE) && (w_kind != MD_NONE) && !flush && !reset;
  // flush beats a same-cycle completion; rdy beats a same-cycle timeout
  assign w_finish            = w_busy && !flush && (md_result_rdy || w_at_limit);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    ctrlMULT     = 1'b0;
    ctrlDIV      = 1'b0;
    stall        = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_state_nxt = S_BUSY;
          stall       = 1'b1;
          ctrlMULT    = (w_kind == MD_MULT);
          ctrlDIV     = (w_kind == MD_DIV);
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (flush)         w_state_nxt = S_IDLE;
        else if (w_finish) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt  = S_IDLE;
        result_valid = !reset;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_opa       <= '0;
      r_opb       <= '0;
      r_rd        <= '0;
      r_op_mult   <= 1'b0;
      r_result    <= '0;
      r_result_rd <= '0;
      r_exc       <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_launch) begin
        r_opa     <= operand_a;
        r_opb     <= operand_b;
        r_rd      <= d_x_instruction[26:22];
        r_op_mult <= (w_kind == MD_MULT);
      end
      if (w_finish) begin
        r_result    <= md_result_rdy ? md_result : '0;
        r_exc       <= md_result_rdy & md_exception;
        r_timeout   <= !md_result_rdy;
        r_result_rd <= r_rd;
      end
    end
  end

  multdiv_busy_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_busy_counter (
    .clk        (clock),
    .rst        (reset),
    .i_clear    (w_launch),
    .i_enable   (w_busy),
    .o_at_limit (w_at_limit)
  );

  assign md_operand_a   = r_opa;
  assign md_operand_b   = r_opb;
  assign result         = r_result;
  assign result_rd      = r_result_rd;
  assign mult_exception = result_valid & r_exc & r_op_mult;
  assign div_exception  = result_valid & r_exc & !r_op_mult;
  assign timeout_error  = result_valid & r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_multdiv_sequencer: directed vector table plus timeout/reset sequences.
// Rev 1.0
// ------------------------------------------------------------------
module tb_multdiv_sequencer;
  import multdiv_sequencer_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] d_x_instruction;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_result_rdy;
  logic        ctrlMULT;
  logic        ctrlDIV;
  logic [31:0] md_operand_a;
  logic [31:0] md_operand_b;
  logic        stall;
  logic [31:0] result;
  logic [4:0]  result_rd;
  logic        result_valid;
  logic        mult_exception;
  logic        div_exception;
  logic        timeout_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic        fl;
    logic        rdy;
    logic [31:0] mres;
    logic        mexc;
    logic        e_mult;
    logic        e_div;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    logic        e_mexc;
    logic        e_dexc;
    logic        e_tout;
    logic [31:0] e_opa;
    logic [31:0] e_opb;
  } vec_t;

  vec_t tbl[$];

  multdiv_sequencer #(.TIMEOUT(40), .CNT_W(6)) dut (
    .clock           (clock),
    .reset           (reset),
    .d_x_instruction (d_x_instruction),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .flush           (flush),
    .md_result       (md_result),
    .md_exception    (md_exception),
    .md_result_rdy   (md_result_rdy),
    .ctrlMULT        (ctrlMULT),
    .ctrlDIV         (ctrlDIV),
    .md_operand_a    (md_operand_a),
    .md_operand_b    (md_operand_b),
    .stall           (stall),
    .result          (result),
    .result_rd       (result_rd),
    .result_valid    (result_valid),
    .mult_exception  (mult_exception),
    .div_exception   (div_exception),
    .timeout_error   (timeout_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] rd);
    return {op, rd, 15'd0, alu, 2'b00};
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, input int a, input int b, input int fl,
                               input int rdy, input int mres, input int mexc, input int em,
                               input int ed, input int es, input int ev, input int eres,
                               input int erd, input int emx, input int edx, input int eto,
                               input int eopa, input int eopb);
    vec_t x;
    x.instr = instr;  x.a = 32'(a);  x.b = 32'(b);  x.fl = 1'(fl);
    x.rdy = 1'(rdy);  x.mres = 32'(mres);  x.mexc = 1'(mexc);
    x.e_mult = 1'(em);  x.e_div = 1'(ed);  x.e_stall = 1'(es);  x.e_valid = 1'(ev);
    x.e_res = 32'(eres);  x.e_rd = 5'(erd);  x.e_mexc = 1'(emx);  x.e_dexc = 1'(edx);
    x.e_tout = 1'(eto);  x.e_opa = 32'(eopa);  x.e_opb = 32'(eopb);
    return x;
  endfunction

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s got %0h expected %0h", tag, fld, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, compare mid-cycle
  task automatic apply(input vec_t x, input string tag);
    d_x_instruction = x.instr;
    operand_a       = x.a;
    operand_b       = x.b;
    flush           = x.fl;
    md_result_rdy   = x.rdy;
    md_result       = x.mres;
    md_exception    = x.mexc;
    @(negedge clock);
    chk(tag, "ctrlMULT",       32'(ctrlMULT),       32'(x.e_mult));
    chk(tag, "ctrlDIV",        32'(ctrlDIV),        32'(x.e_div));
    chk(tag, "stall",          32'(stall),          32'(x.e_stall));
    chk(tag, "result_valid",   32'(result_valid),   32'(x.e_valid));
    chk(tag, "result",         result,              x.e_res);
    chk(tag, "result_rd",      32'(result_rd),      32'(x.e_rd));
    chk(tag, "mult_exception", 32'(mult_exception), 32'(x.e_mexc));
    chk(tag, "div_exception",  32'(div_exception),  32'(x.e_dexc));
    chk(tag, "timeout_error",  32'(timeout_error),  32'(x.e_tout));
    chk(tag, "md_operand_a",   md_operand_a,        x.e_opa);
    chk(tag, "md_operand_b",   md_operand_b,        x.e_opb);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] nop, notmd, m1, m2, m3, m4, m5, m6, m7, m8, d2, d9;
    nop   = 32'd0;
    notmd = mk(5'b00101, c_aluop_mult, 5'd3);
    m1 = mk(c_opcode_alu, c_aluop_mult, 5'd1);
    m2 = mk(c_opcode_alu, c_aluop_mult, 5'd2);
    m3 = mk(c_opcode_alu, c_aluop_mult, 5'd3);
    m4 = mk(c_opcode_alu, c_aluop_mult, 5'd4);
    m5 = mk(c_opcode_alu, c_aluop_mult, 5'd5);
    m6 = mk(c_opcode_alu, c_aluop_mult, 5'd6);
    m7 = mk(c_opcode_alu, c_aluop_mult, 5'd7);
    m8 = mk(c_opcode_alu, c_aluop_mult, 5'd8);
    d2 = mk(c_opcode_alu, c_aluop_div,  5'd2);
    d9 = mk(c_opcode_alu, c_aluop_div,  5'd9);

    // Reset state, then mult 6*7 with rdy 4 cycles after launch
    tbl.push_back(mkv(nop, 0, 0,  0,0,0,0,  0,0,0,0,  0,0,0,0,0,  0,0));
    tbl.push_back(mkv(m3, 6, 7,   0,0,0,0,  1,0,1,0,  0,0,0,0,0,  0,0));
    tbl.push_back(mkv(m3, 6, 7,   0,0,0,0,  0,0,1,0,  0,0,0,0,0,  6,7));
    tbl.push_back(mkv(m3, 6, 7,   0,0,0,0,  0,0,1,0,  0,0,0,0,0,  6,7));
    tbl.push_back(mkv(m3, 6, 7,   0,0,0,0,  0,0,1,0,  0,0,0,0,0,  6,7));
    tbl.push_back(mkv(m3, 6, 7,   0,1,42,0, 0,0,1,0,  0,0,0,0,0,  6,7));
    tbl.push_back(mkv(m3, 6, 7,   0,0,0,0,  0,0,0,1,  42,3,0,0,0, 6,7));
    tbl.push_back(mkv(nop, 0, 0,  0,0,0,0,  0,0,0,0,  42,3,0,0,0, 6,7));
    // div 100/0 faulting
    tbl.push_back(mkv(d9, 100, 0, 0,0,0,0,  0,1,1,0,  42,3,0,0,0, 6,7));
    tbl.push_back(mkv(d9, 100, 0, 0,1,0,1,  0,0,1,0,  42,3,0,0,0, 100,0));
    tbl.push_back(mkv(d9, 100, 0, 0,0,0,0,  0,0,0,1,  0,9,0,1,0,  100,0));
    tbl.push_back(mkv(nop, 0, 0,  0,0,0,0,  0,0,0,0,  0,9,0,0,0,  100,0));
    // back-to-back mults 2*3 then 4*5
    tbl.push_back(mkv(m4, 2, 3,   0,0,0,0,  1,0,1,0,  0,9,0,0,0,  100,0));
    tbl.push_back(mkv(m4, 2, 3,   0,1,6,0,  0,0,1,0,  0,9,0,0,0,  2,3));
    tbl.push_back(mkv(m4, 2, 3,   0,0,0,0,  0,0,0,1,  6,4,0,0,0,  2,3));
    tbl.push_back(mkv(m5, 4, 5,   0,0,0,0,  1,0,1,0,  6,4,0,0,0,  2,3));
    tbl.push_back(mkv(m5, 4, 5,   0,1,20,0, 0,0,1,0,  6,4,0,0,0,  4,5));
    tbl.push_back(mkv(m5, 4, 5,   0,0,0,0,  0,0,0,1,  20,5,0,0,0, 4,5));
    tbl.push_back(mkv(nop, 0, 0,  0,1,99,1, 0,0,0,0,  20,5,0,0,0, 4,5));
    // flush two cycles into BUSY, late rdy, flush/non-alu in IDLE
    tbl.push_back(mkv(m6, 8, 8,   0,0,0,0,  1,0,1,0,  20,5,0,0,0, 4,5));
    tbl.push_back(mkv(m6, 8, 8,   0,0,0,0,  0,0,1,0,  20,5,0,0,0, 8,8));
    tbl.push_back(mkv(m6, 8, 8,   1,0,0,0,  0,0,1,0,  20,5,0,0,0, 8,8));
    tbl.push_back(mkv(nop, 0, 0,  0,1,64,0, 0,0,0,0,  20,5,0,0,0, 8,8));
    tbl.push_back(mkv(m7, 1, 2,   1,0,0,0,  0,0,0,0,  20,5,0,0,0, 8,8));
    tbl.push_back(mkv(notmd, 1, 2, 0,0,0,0, 0,0,0,0,  20,5,0,0,0, 8,8));
    // flush and rdy together: flush wins
    tbl.push_back(mkv(d2, 10, 3,  0,0,0,0,  0,1,1,0,  20,5,0,0,0, 8,8));
    tbl.push_back(mkv(d2, 10, 3,  1,1,3,0,  0,0,1,0,  20,5,0,0,0, 10,3));
    tbl.push_back(mkv(nop, 0, 0,  0,0,0,0,  0,0,0,0,  20,5,0,0,0, 10,3));
    // mult overflow
    tbl.push_back(mkv(m8, 7, 7,   0,0,0,0,  1,0,1,0,  20,5,0,0,0, 10,3));
    tbl.push_back(mkv(m8, 7, 7,   0,1,49,1, 0,0,1,0,  20,5,0,0,0, 7,7));
    tbl.push_back(mkv(m8, 7, 7,   0,0,0,0,  0,0,0,1,  49,8,1,0,0, 7,7));
    tbl.push_back(mkv(nop, 0, 0,  0,0,0,0,  0,0,0,0,  49,8,0,0,0, 7,7));

    reset = 1'b1;
    d_x_instruction = '0; operand_a = '0; operand_b = '0; flush = 1'b0;
    md_result = '0; md_exception = 1'b0; md_result_rdy = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    // Timeout: unit never answers, completion forced at T+41
    apply(mkv(m1, 11, 13, 0,0,0,0, 1,0,1,0, 49,8,0,0,0, 7,7), "tmo_launch");
    for (int k = 1; k <= 40; k++)
      apply(mkv(m1, 11, 13, 0,0,0,0, 0,0,1,0, 49,8,0,0,0, 11,13), $sformatf("tmo_busy%0d", k));
    apply(mkv(m1, 11, 13, 0,0,0,0, 0,0,0,1, 0,1,0,0,1, 11,13), "tmo_done");
    apply(mkv(nop, 0, 0, 0,0,0,0, 0,0,0,0, 0,1,0,0,0, 11,13), "tmo_idle");

    // Reset in BUSY, then a fresh 9*9
    apply(mkv(m2, 5, 5, 0,0,0,0, 1,0,1,0, 0,1,0,0,0, 11,13), "rst_launch");
    reset = 1'b1;
    apply(mkv(m2, 5, 5, 0,0,0,0, 0,0,1,0, 0,1,0,0,0, 5,5), "rst_busy");
    reset = 1'b0;
    apply(mkv(nop, 0, 0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0), "rst_after");
    apply(mkv(m7, 9, 9, 0,0,0,0, 1,0,1,0, 0,0,0,0,0, 0,0), "fresh_launch");
    apply(mkv(m7, 9, 9, 0,0,0,0, 0,0,1,0, 0,0,0,0,0, 9,9), "fresh_busy");
    apply(mkv(m7, 9, 9, 0,1,81,0, 0,0,1,0, 0,0,0,0,0, 9,9), "fresh_rdy");
    apply(mkv(m7, 9, 9, 0,0,0,0, 0,0,0,1, 81,7,0,0,0, 9,9), "fresh_done");
    apply(mkv(nop, 0, 0, 0,0,0,0, 0,0,0,0, 81,7,0,0,0, 9,9), "fresh_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
